axil_csr_regs: RTL

AXIL_CSR_REGS -- requirements
Module: axil_csr_regs

---
 rtl/axil_csr_regs.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/axil_csr_regs.sv
// axil_csr_regs -- AXI4-Lite control/status register block.
//
// Purpose: small CSR slave with an ID constant, a scratch register, a control
// register driven straight out on ctrl_out, a 64-bit free-running cycle
// counter read through a tear-free low/high shadow pair, an 8-bit sticky
// event STATUS register (write-1-to-clear) and an IRQ mask producing a
// registered level interrupt.
//
// Ports:
//   clk, rst            sole clock (rising edge), asynchronous active-high reset
//   s_axil_aw*/w*/b*    AXI-Lite write address / data / response channels
//   s_axil_ar*/r*       AXI-Lite read address / data channels
//   event_in[7:0]       single-cycle event pulses, sticky-set into STATUS
//   ctrl_out[31:0]      CTRL register contents
//   irq                 |(STATUS & IRQ_MASK), registered
//
// Register map (byte offsets, addr[1:0] ignored):
//   0x00 ID (RO)   0x04 SCRATCH (RW)   0x08 CTRL (RW)   0x0C CNT_LO (RO)
//   0x10 CNT_HI (RO shadow)   0x14 STATUS (W1C, 7:0)   0x18 IRQ_MASK (RW, 7:0)
//
// Handshake semantics (valid/ready): a transfer happens on a rising edge where
// both valid and ready are high. awready and wready are one combinational
// signal, high only when awvalid && wvalid && !bvalid, so address and data are
// always taken together in a single cycle. arready is high only when
// arvalid && !rvalid. bvalid/rvalid rise the cycle after acceptance and hold
// their payload stable until the matching ready is seen; a new transfer on
// that channel can only be accepted once the response has been retired.
// All ready outputs are masked while rst is high.

module axil_csr_regs #(
  parameter int          ADDR_WIDTH = 16,
  parameter logic [31:0] ID_VALUE   = 32'h0001_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  // AW channel
  input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic [2:0]            s_axil_awprot,
  input  logic                  s_axil_awvalid,
  output logic                  s_axil_awready,
  // W channel
  input  logic [31:0]           s_axil_wdata,
  input  logic [3:0]            s_axil_wstrb,
  input  logic                  s_axil_wvalid,
  output logic                  s_axil_wready,
  // B channel
  output logic [1:0]            s_axil_bresp,
  output logic                  s_axil_bvalid,
  input  logic                  s_axil_bready,
  // AR channel
  input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic [2:0]            s_axil_arprot,
  input  logic                  s_axil_arvalid,
  output logic                  s_axil_arready,
  // R channel
  output logic [31:0]           s_axil_rdata,
  output logic [1:0]            s_axil_rresp,
  output logic                  s_axil_rvalid,
  input  logic                  s_axil_rready,
  // sideband
  input  logic [7:0]            event_in,
  output logic [31:0]           ctrl_out,
  output logic                  irq
);

  localparam int IDXW = ADDR_WIDTH - 2;

  localparam logic [IDXW-1:0] IDX_ID       = IDXW'(0);
  localparam logic [IDXW-1:0] IDX_SCRATCH  = IDXW'(1);
  localparam logic [IDXW-1:0] IDX_CTRL     = IDXW'(2);
  localparam logic [IDXW-1:0] IDX_CNT_LO   = IDXW'(3);
  localparam logic [IDXW-1:0] IDX_CNT_HI   = IDXW'(4);
  localparam logic [IDXW-1:0] IDX_STATUS   = IDXW'(5);
  localparam logic [IDXW-1:0] IDX_IRQ_MASK = IDXW'(6);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // state
  logic [31:0] scratch_q,  scratch_d;
  logic [31:0] ctrl_q,     ctrl_d;
  logic [7:0]  status_q,   status_d;
  logic [7:0]  irq_mask_q, irq_mask_d;
  logic [63:0] cnt_q,      cnt_d;
  logic [31:0] cnt_hi_q,   cnt_hi_d;
  logic        bvalid_q,   bvalid_d;
  logic [1:0]  bresp_q,    bresp_d;
  logic        rvalid_q,   rvalid_d;
  logic [1:0]  rresp_q,    rresp_d;
  logic [31:0] rdata_q,    rdata_d;
  logic        irq_q,      irq_d;

  // decode
  logic [IDXW-1:0] w_idx;
  logic [IDXW-1:0] r_idx;
  logic            w_accept;
  logic            r_accept;
  logic            w_mapped;
  logic            r_mapped;
  logic [31:0]     r_word;
  logic [7:0]      status_clr;

  // prot bits and the byte-offset address bits carry no meaning here
  logic unused_inputs;
  assign unused_inputs = ^{s_axil_awprot, s_axil_arprot,
                           s_axil_awaddr[1:0], s_axil_araddr[1:0]};

  function automatic logic [31:0] apply_strb(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

  assign w_idx    = s_axil_awaddr[ADDR_WIDTH-1:2];
  assign r_idx    = s_axil_araddr[ADDR_WIDTH-1:2];
  assign w_accept = !rst && s_axil_awvalid && s_axil_wvalid && !bvalid_q;
  assign r_accept = !rst && s_axil_arvalid && !rvalid_q;
  assign w_mapped = (w_idx <= IDX_IRQ_MASK);

  // read mux works on current register values, so a write landing on the
  // same edge is not visible to a read accepted on that edge
  always_comb begin
    r_word   = 32'd0;
    r_mapped = 1'b1;
    case (r_idx)
      IDX_ID:       r_word = ID_VALUE;
      IDX_SCRATCH:  r_word = scratch_q;
      IDX_CTRL:     r_word = ctrl_q;
      IDX_CNT_LO:   r_word = cnt_q[31:0];
      IDX_CNT_HI:   r_word = cnt_hi_q;
      IDX_STATUS:   r_word = {24'd0, status_q};
      IDX_IRQ_MASK: r_word = {24'd0, irq_mask_q};
      default: begin
        r_word   = 32'd0;
        r_mapped = 1'b0;
      end
    endcase
  end

  // write side and register next-state
  always_comb begin
    scratch_d  = scratch_q;
    ctrl_d     = ctrl_q;
    irq_mask_d = irq_mask_q;
    status_clr = 8'd0;
    if (w_accept) begin
      case (w_idx)
        IDX_SCRATCH:  scratch_d  = apply_strb(scratch_q, s_axil_wdata, s_axil_wstrb);
        IDX_CTRL:     ctrl_d     = apply_strb(ctrl_q, s_axil_wdata, s_axil_wstrb);
        IDX_IRQ_MASK: if (s_axil_wstrb[0]) irq_mask_d = s_axil_wdata[7:0];
        IDX_STATUS:   if (s_axil_wstrb[0]) status_clr = s_axil_wdata[7:0];
        default:      ;
      endcase
    end
    // a new event wins over a simultaneous clear of the same bit
    status_d = (status_q & ~status_clr) | event_in;
    cnt_d    = cnt_q + 64'd1;
    irq_d    = |(status_q & irq_mask_q);
  end

  // response channels
  always_comb begin
    bvalid_d = bvalid_q;
    bresp_d  = bresp_q;
    if (w_accept) begin
      bvalid_d = 1'b1;
      bresp_d  = w_mapped ? RESP_OKAY : RESP_SLVERR;
    end else if (bvalid_q && s_axil_bready) begin
      bvalid_d = 1'b0;
    end

    rvalid_d = rvalid_q;
    rresp_d  = rresp_q;
    rdata_d  = rdata_q;
    cnt_hi_d = cnt_hi_q;
    if (r_accept) begin
      rvalid_d = 1'b1;
      rresp_d  = r_mapped ? RESP_OKAY : RESP_SLVERR;
      rdata_d  = r_word;
      // capture the high word in the same cycle as the low word so a
      // following CNT_HI read cannot see a carry that happened in between
      if (r_idx == IDX_CNT_LO) cnt_hi_d = cnt_q[63:32];
    end else if (rvalid_q && s_axil_rready) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scratch_q  <= 32'd0;
      ctrl_q     <= 32'd0;
      status_q   <= 8'd0;
      irq_mask_q <= 8'd0;
      cnt_q      <= 64'd0;
      cnt_hi_q   <= 32'd0;
      bvalid_q   <= 1'b0;
      bresp_q    <= 2'b00;
      rvalid_q   <= 1'b0;
      rresp_q    <= 2'b00;
      rdata_q    <= 32'd0;
      irq_q      <= 1'b0;
    end else begin
      scratch_q  <= scratch_d;
      ctrl_q     <= ctrl_d;
      status_q   <= status_d;
      irq_mask_q <= irq_mask_d;
      cnt_q      <= cnt_d;
      cnt_hi_q   <= cnt_hi_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      rvalid_q   <= rvalid_d;
      rresp_q    <= rresp_d;
      rdata_q    <= rdata_d;
      irq_q      <= irq_d;
    end
  end

  assign s_axil_awready = w_accept;
  assign s_axil_wready  = w_accept;
  assign s_axil_bvalid  = bvalid_q;
  assign s_axil_bresp   = bresp_q;
  assign s_axil_arready = r_accept;
  assign s_axil_rvalid  = rvalid_q;
  assign s_axil_rresp   = rresp_q;
  assign s_axil_rdata   = rdata_q;
  assign ctrl_out       = ctrl_q;
  assign irq            = irq_q;

endmodule
